ldst_replay_ctrl: RTL
=====================

Name: ldst_replay_ctrl

Overview:
- Sequences one warp's load/store through the L1 banks as repeated passes until every enabled thread has been serviced.
- Each per-bank setup unit services at most one thread per pass (lowest SP ID wins), so bank conflicts need replays.
- This block holds the pending-thread mask, drives it as cur_mask to all per-bank setup units, and retires the threads reported as serviced.
- It stalls the MP pipeline until the last pass completes.

Parameters:
- SP_PER_MP, 8, number of SPs per MP; width of every thread mask.
- CONTROL_WIDTH, 17, number of control bits; ld is bit 15, st is bit 16.
- PASS_WIDTH, $clog2(SP_PER_MP)+1, width of the pass counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  new warp instruction offered.
- req_ready  output  1  controller can accept a request.
- req_mask  input  SP_PER_MP  enabled-thread mask of the offered instruction.
- req_control  input  CONTROL_WIDTH  control bits of the offered instruction.
- pass_valid  output  1  a pass is presented to the banks.
- pass_mask  output  SP_PER_MP  pending threads; drives cur_mask of every setup unit.
- pass_control  output  CONTROL_WIDTH  registered copy of req_control, held for the whole instruction.
- mem_ack  input  1  L1 banks accepted the current pass.
- served_mask  input  SP_PER_MP  OR of all per-bank match-winner one-hots for the current pass.
- stall  output  1  hold the upstream pipeline.
- done  output  1  one-cycle pulse: instruction fully serviced.
- pass_count  output  PASS_WIDTH  passes used by the last finished instruction.
- err  output  1  sticky no-progress error.

Behaviour:
- Reset values (asynchronous, active-high; takes effect immediately, including mid-operation):
  - state=IDLE, all masks and counters 0.
  - pass_valid=0, done=0, err=0, stall=0, req_ready=1.
  - The in-flight instruction is dropped.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - req_ready=1, stall=0.
  - On req_valid, capture pending<=req_mask and ctrl<=req_control; clear the pass counter.
  - Go to ISSUE if (bit15|bit16) and req_mask!=0; otherwise go to DONE with pass_count=0.
- ISSUE:
  - pass_valid=1, pass_mask=pending, stall=1, req_ready=0.
  - Hold all outputs stable until mem_ack.
  - On mem_ack:
    - pending <= pending & ~served_mask. served_mask bits outside pending are ignored.
    - The pass counter increments, saturating at 2^PASS_WIDTH-1.
    - If the new pending==0, go to DONE.
    - If (served_mask & pending)==0, set err, go to DONE, and clear pending.
    - Otherwise remain in ISSUE; the next pass is presented the following cycle.
- DONE:
  - done=1 for exactly one cycle; pass_count updated this cycle and held until the next DONE.
  - stall=1, pass_valid=0.
  - Next state is IDLE.
- Latency:
  - Accept in cycle 0; first pass_valid in cycle 1.
  - With same-cycle mem_ack, N passes give done in cycle N+1, then IDLE in cycle N+2.
- A new request cannot be accepted in DONE; back-to-back issue has a 1-cycle bubble.
- err stays set until rst.
- All outputs are registered or decoded from registered state only; no combinational path from mem_ack/served_mask to outputs.

Decomposition:
- Shared package ldst_pkg holds:
  - the state enum (IDLE, ISSUE, DONE);
  - constants LD_BIT=15, ST_BIT=16;
  - a function is_ldst(control).
- One sub-module is natural: ldst_pass_counter, a saturating up-counter with clear and enable. Everything else stays in one always_ff plus next-state logic.

Test Plan:
- No conflict: req_mask=8'hFF, control bit15=1, banks all distinct, served_mask=8'hFF with ack in cycle 1 -> done in cycle 2, pass_count=1, err=0.
- Full conflict: all 8 SPs on bank 3, served_mask one-hot from LSB each ack -> pass_mask 8'hFF,8'hFE,…,8'h80 on successive cycles; done after 8 passes, pass_count=8.
- Non-ldst or empty mask: control bits15/16=0, or req_mask=0 with st=1 -> no pass_valid, done one cycle after accept, pass_count=0.
- Backpressure: mem_ack held low 5 cycles during a pass of pass_mask=8'h0F -> pass_mask/pass_valid stable throughout, counter unchanged; after ack with served=8'h05, next pass_mask=8'h0A.
- No progress: pending=8'h0C, ack with served_mask=8'h03 -> err=1, done next cycle, pending cleared, err persists through the next request.
- Reset mid-operation: assert rst during pass 2 of a conflicting warp -> same-cycle asynchronous return to IDLE, pass_valid=0, stall=0, req_ready=1, and a new request is accepted normally after release.

Source files
------------

// File: rtl/ldst_pkg.sv
// Shared types and helpers for the load/store replay controller.
// Holds the FSM state encoding and the ld/st control-bit decode.
package ldst_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int LD_BIT = 15;
   localparam int ST_BIT = 16;

   function automatic logic is_ldst(input logic [ST_BIT:0] control);
      return control[LD_BIT] | control[ST_BIT];
   endfunction

endpackage

// File: rtl/ldst_pass_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Counts the replay passes used by one warp instruction.
module ldst_pass_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ldst_replay_ctrl.sv
// Replays one warp's load/store through the L1 banks until every enabled
// thread has been serviced, stalling the MP pipeline meanwhile.
module ldst_replay_ctrl
   import ldst_pkg::*;
#(
   parameter int SP_PER_MP     = 8,
   parameter int CONTROL_WIDTH = 17,
   parameter int PASS_WIDTH    = $clog2(SP_PER_MP) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [SP_PER_MP-1:0]     req_mask,
   input  logic [CONTROL_WIDTH-1:0] req_control,
   output logic                     pass_valid,
   output logic [SP_PER_MP-1:0]     pass_mask,
   output logic [CONTROL_WIDTH-1:0] pass_control,
   input  logic                     mem_ack,
   input  logic [SP_PER_MP-1:0]     served_mask,
   output logic                     stall,
   output logic                     done,
   output logic [PASS_WIDTH-1:0]    pass_count,
   output logic                     err
);

   state_e                   state_q, state_d;
   logic [SP_PER_MP-1:0]     pending_q, pending_d;
   logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic                     err_q, err_d;
   logic [PASS_WIDTH-1:0]    last_count_q, last_count_d;
   logic [PASS_WIDTH-1:0]    cnt;
   logic                     cnt_clr;
   logic                     cnt_en;
   logic [SP_PER_MP-1:0]     progress;
   logic [SP_PER_MP-1:0]     remaining;

   ldst_pass_counter #(
      .WIDTH(PASS_WIDTH)
   ) u_pass_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .count(cnt)
   );

   // Served bits for threads no longer pending must not count as progress.
   assign progress  = served_mask & pending_q;
   assign remaining = pending_q & ~served_mask;

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      ctrl_d       = ctrl_q;
      err_d        = err_q;
      last_count_d = last_count_q;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               pending_d = req_mask;
               ctrl_d    = req_control;
               cnt_clr   = 1'b1;
               if (is_ldst(req_control[ST_BIT:0]) && (req_mask != '0)) begin
                  state_d = ISSUE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               cnt_en = 1'b1;
               if (progress == '0) begin
                  err_d     = 1'b1;
                  pending_d = '0;
                  state_d   = DONE;
               end else begin
                  pending_d = remaining;
                  if (remaining == '0) begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: begin
            last_count_d = cnt;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         ctrl_q       <= '0;
         err_q        <= 1'b0;
         last_count_q <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         ctrl_q       <= ctrl_d;
         err_q        <= err_d;
         last_count_q <= last_count_d;
      end
   end

   // The counter has settled by the DONE cycle, so it is shown directly there.
   assign req_ready    = (state_q == IDLE);
   assign pass_valid   = (state_q == ISSUE);
   assign pass_mask    = (state_q == ISSUE) ? pending_q : '0;
   assign pass_control = ctrl_q;
   assign stall        = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign pass_count   = (state_q == DONE) ? cnt : last_count_q;
   assign err          = err_q;

endmodule
